// File: rtl/parity_stream_checker.sv
`default_nettype none
// ============================================================================
// parity_stream_checker
// Accumulates parity over valid/ready packets and flags a mismatch against the
// expected parity carried on the last word. Optional: PARITY_LANE_EN.
// Revision: 1.0
// ============================================================================
module parity_stream_checker #(
  parameter int WIDTH     = 32,
  parameter int LANES     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 odd_mode,
  input  logic                 clear_count,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  input  logic                 in_parity,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_parity,
  output logic                 out_error,
  output logic [CNT_WIDTH-1:0] out_words,
`ifdef PARITY_LANE_EN
  output logic [LANES-1:0]     out_lane_parity,
`endif
  output logic [CNT_WIDTH-1:0] error_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  if (WIDTH % LANES != 0) begin : g_bad_lanes
    $error("WIDTH must be divisible by LANES");
  end

  state_t                r_state, w_state_nxt;
  logic                  r_acc, w_acc_nxt;
  logic [CNT_WIDTH-1:0]  r_words, w_words_nxt, w_words_inc;
  logic                  r_par, w_par_nxt;
  logic                  r_err, w_err_nxt;
  logic [CNT_WIDTH-1:0]  r_owords, w_owords_nxt;
  logic [CNT_WIDTH-1:0]  r_ecnt, w_ecnt_nxt;
  logic                  w_in_fire, w_out_fire, w_last_fire, w_load_err;

  assign in_ready    = reset & ((r_state != S_DONE) | out_ready);
  assign out_valid   = (r_state == S_DONE);
  assign out_parity  = r_par;
  assign out_error   = r_err;
  assign out_words   = r_owords;
  assign error_count = r_ecnt;

  assign w_in_fire   = in_valid & in_ready;
  assign w_out_fire  = out_valid & out_ready;
  assign w_last_fire = w_in_fire & in_last;
  assign w_words_inc = (r_words == {CNT_WIDTH{1'b1}}) ? r_words : r_words + c_ONE;

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_words_nxt  = r_words;
    w_par_nxt    = r_par;
    w_err_nxt    = r_err;
    w_owords_nxt = r_owords;
    w_ecnt_nxt   = r_ecnt;
    w_load_err   = 1'b0;

    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_in_fire) w_state_nxt = in_last ? S_DONE : S_ACCUM;
      end
      S_DONE: begin
        if (w_out_fire) begin
          if (w_in_fire) w_state_nxt = in_last ? S_DONE : S_ACCUM;
          else           w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // The accumulator is already clear in DONE, so a word accepted alongside
    // a pop starts a fresh packet through the same path.
    if (w_in_fire) begin
      if (in_last) begin
        w_par_nxt    = r_acc ^ (^in_data) ^ odd_mode;
        w_err_nxt    = w_par_nxt != in_parity;
        w_owords_nxt = w_words_inc;
        w_acc_nxt    = 1'b0;
        w_words_nxt  = '0;
        w_load_err   = w_err_nxt;
      end else begin
        w_acc_nxt    = r_acc ^ (^in_data);
        w_words_nxt  = w_words_inc;
      end
    end

    if (clear_count)
      w_ecnt_nxt = w_load_err ? c_ONE : '0;
    else if (w_load_err && (r_ecnt != {CNT_WIDTH{1'b1}}))
      w_ecnt_nxt = r_ecnt + c_ONE;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_acc    <= 1'b0;
      r_words  <= '0;
      r_par    <= 1'b0;
      r_err    <= 1'b0;
      r_owords <= '0;
      r_ecnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_words  <= w_words_nxt;
      r_par    <= w_par_nxt;
      r_err    <= w_err_nxt;
      r_owords <= w_owords_nxt;
      r_ecnt   <= w_ecnt_nxt;
    end
  end

`ifdef PARITY_LANE_EN
  localparam int c_LANE_W = WIDTH / LANES;

  logic [LANES-1:0] w_lane_word;
  logic [LANES-1:0] r_lane_acc;
  logic [LANES-1:0] r_lane_par;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_lane_word[gi] = ^in_data[gi*c_LANE_W +: c_LANE_W];
  end

  assign out_lane_parity = r_lane_par;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_lane_acc <= '0;
      r_lane_par <= '0;
    end else if (w_in_fire) begin
      if (in_last) begin
        r_lane_par <= r_lane_acc ^ w_lane_word ^ {LANES{odd_mode}};
        r_lane_acc <= '0;
      end else begin
        r_lane_acc <= r_lane_acc ^ w_lane_word;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_stream_checker.sv
`default_nettype none
// ============================================================================
// tb_parity_stream_checker
// Directed and randomized stimulus against a packet-level parity model.
// Revision: 1.0
// ============================================================================
module tb_parity_stream_checker;

  localparam int WIDTH  = 32;
  localparam int LANES  = 4;
  localparam int CW     = 4;
  localparam int SATMAX = (1 << CW) - 1;
  localparam int LW     = WIDTH / LANES;

  logic              clock = 1'b0;
  logic              reset;
  logic              odd_mode, clear_count, in_valid, in_last, in_parity, out_ready;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready, out_valid, out_parity, out_error;
  logic [CW-1:0]     out_words, error_count;
`ifdef PARITY_LANE_EN
  logic [LANES-1:0]  out_lane_parity;
`endif

  parity_stream_checker #(.WIDTH(WIDTH), .LANES(LANES), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .odd_mode(odd_mode), .clear_count(clear_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .in_parity(in_parity), .out_valid(out_valid), .out_ready(out_ready),
    .out_parity(out_parity), .out_error(out_error), .out_words(out_words),
`ifdef PARITY_LANE_EN
    .out_lane_parity(out_lane_parity),
`endif
    .error_count(error_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Packet-level model: word count and parity of all bits seen so far.
  int         run_cnt;
  bit         run_par;
  bit [LANES-1:0] run_lane;
  bit         exp_valid, exp_par, exp_err;
  int         exp_words, exp_ecnt;
  bit [LANES-1:0] exp_lane;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    run_cnt = 0; run_par = 0; run_lane = '0;
    exp_valid = 0; exp_par = 0; exp_err = 0; exp_words = 0; exp_ecnt = 0; exp_lane = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"},   32'(out_valid),   32'(exp_valid));
    check({tag, ".out_parity"},  32'(out_parity),  32'(exp_par));
    check({tag, ".out_error"},   32'(out_error),   32'(exp_err));
    check({tag, ".out_words"},   32'(out_words),   32'(exp_words));
    check({tag, ".error_count"}, 32'(error_count), 32'(exp_ecnt));
`ifdef PARITY_LANE_EN
    check({tag, ".lane_parity"}, 32'(out_lane_parity), 32'(exp_lane));
`endif
  endtask

  // One clock: apply inputs, check in_ready, advance model, check outputs.
  task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit l, input bit p,
                       input bit odd, input bit ordy, input bit clr, input string tag);
    bit accept, pop, err_load;
    logic [WIDTH-1:0] t;
    in_valid = v; in_data = d; in_last = l; in_parity = p;
    odd_mode = odd; out_ready = ordy; clear_count = clr;
    #1;
    accept = v && (!exp_valid || ordy);
    pop    = exp_valid && ordy;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(!exp_valid || ordy));
    @(posedge clock);
    err_load = 0;
    if (accept) begin
      run_cnt++;
      run_par ^= bit'($countones(d) % 2);
      for (int i = 0; i < LANES; i++) begin
        t = d >> (i * LW);
        run_lane[i] ^= bit'($countones(t & ((1 << LW) - 1)) % 2);
      end
      if (l) begin
        exp_par   = run_par ^ odd;
        exp_err   = exp_par != p;
        exp_words = (run_cnt > SATMAX) ? SATMAX : run_cnt;
        exp_lane  = run_lane ^ {LANES{odd}};
        exp_valid = 1;
        err_load  = exp_err;
        run_cnt = 0; run_par = 0; run_lane = '0;
      end
    end
    if (pop && !(accept && l)) exp_valid = 0;
    if (clr)           exp_ecnt = err_load ? 1 : 0;
    else if (err_load) exp_ecnt = (exp_ecnt >= SATMAX) ? SATMAX : exp_ecnt + 1;
    @(negedge clock);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b1; in_data = '1; in_last = 1'b0; in_parity = 1'b0;
    odd_mode = 1'b0; out_ready = 1'b1; clear_count = 1'b0;
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    model_clear();
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b0;
    check_outputs("rst");
  endtask

  initial begin
    model_clear();
    @(negedge clock);
    do_reset();

    // Two-word even packet
    cycle(1, 32'h0000_0001, 0, 0, 0, 1, 0, "tp1a");
    cycle(1, 32'h0000_0003, 1, 1, 0, 1, 0, "tp1b");
    check("tp1.valid", 32'(out_valid), 32'd1);
    check("tp1.par",   32'(out_parity), 32'd1);
    check("tp1.words", 32'(out_words), 32'd2);
    cycle(0, '0, 0, 0, 0, 1, 0, "pop1");

    // Odd-mode single word with error
    cycle(1, 32'h0000_000F, 1, 0, 1, 1, 0, "tp2");
    check("tp2.err",  32'(out_error), 32'd1);
    check("tp2.ecnt", 32'(error_count), 32'd1);

    // Backpressure: result pending, further input ignored
    for (int i = 0; i < 5; i++)
      cycle(1, 32'h1234_5678, 1, 0, 1, 0, 0, "bp");
    check("bp.words", 32'(out_words), 32'd1);
    cycle(1, 32'h8000_0000, 1, 1, 0, 1, 0, "bp_pushpop");
    check("bp.valid", 32'(out_valid), 32'd1);
    check("bp.par",   32'(out_parity), 32'd1);
    check("bp.err",   32'(out_error), 32'd0);

    // Error-count saturation, then clear together with an error load
    for (int i = 0; i < 17; i++)
      cycle(1, 32'h0000_0001, 1, 0, 0, 1, 0, "sat");
    check("sat.ecnt", 32'(error_count), 32'(SATMAX));
    cycle(1, 32'h0000_0001, 1, 0, 0, 1, 1, "clr_err");
    check("clr.ecnt", 32'(error_count), 32'd1);
    cycle(0, '0, 0, 0, 0, 1, 1, "clr_only");

    // Word-count saturation across a long packet
    for (int i = 0; i < 20; i++)
      cycle(1, 32'h0000_0003, 0, 0, 0, 1, 0, "long");
    cycle(1, 32'h0000_0000, 1, 0, 0, 1, 0, "long_last");
    check("long.words", 32'(out_words), 32'(SATMAX));
    cycle(0, '0, 0, 0, 0, 1, 0, "pop2");

    // Reset mid-packet discards the partial packet
    cycle(1, 32'h0000_0001, 0, 0, 0, 1, 0, "mid1");
    cycle(1, 32'h0000_0007, 0, 0, 0, 1, 0, "mid2");
    do_reset();
    cycle(1, 32'h0000_0001, 1, 1, 0, 1, 0, "post_rst");
    check("post_rst.par", 32'(out_parity), 32'd1);
    check("post_rst.words", 32'(out_words), 32'd1);

`ifdef PARITY_LANE_EN
    cycle(1, 32'h0102_0300, 1, 0, 0, 1, 0, "lane");
    check("lane.bits", 32'(out_lane_parity), 32'b1100);
    check("lane.par",  32'(out_parity), 32'd0);
`endif

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(199) == 0) do_reset();
      else cycle($urandom_range(3) != 0, WIDTH'($urandom), $urandom_range(2) == 0,
                 1'($urandom), 1'($urandom), $urandom_range(2) != 0,
                 $urandom_range(39) == 0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/parity_stream_checker.md
Name: parity_stream_checker

Overview:
Sequential successor to the combinational XOR-reduction parity block. Accumulates parity over multi-word packets on a valid/ready stream and compares the result against an expected parity bit delivered with the last word. Presents a per-packet result (parity, error flag, word count) on an output handshake and keeps a saturating error counter. Sits between a packet source and downstream integrity logic.

Parameters:
WIDTH, 32, data word width in bits; must be divisible by LANES
LANES, 4, number of equal-width lanes for per-lane parity (optional feature only)
CNT_WIDTH, 16, width of the word counter and the error counter

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-low
odd_mode  in  1  0 = even parity, 1 = odd parity; sampled on the last-word transfer
clear_count  in  1  synchronous clear of error_count
in_valid  in  1  input word valid
in_ready  out  1  input can accept
in_data  in  WIDTH  input word
in_last  in  1  marks the final word of a packet
in_parity  in  1  expected packet parity; sampled only on a last-word transfer
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_parity  out  1  computed packet parity
out_error  out  1  1 when out_parity != expected in_parity
out_words  out  CNT_WIDTH  words in packet, saturating
error_count  out  CNT_WIDTH  packets with error, saturating

Behaviour:
- Reset (reset==0 at a rising edge): state IDLE; accumulator, word counter, out_parity, out_error, out_words, and error_count are 0; out_valid is 0. in_ready is 0 while reset is low. A partial packet in progress is discarded.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- in_ready = !out_valid | out_ready (combinational); a result can be popped and a new word accepted in the same cycle.
- States:
  - IDLE: no words accumulated. A non-last transfer goes to ACCUM. A last transfer goes to DONE.
  - ACCUM: mid-packet. On each transfer: acc ^= ^in_data and words++, saturating at 2^CNT_WIDTH-1. A last transfer goes to DONE.
  - DONE: result held, out_valid=1. An output transfer with no input transfer goes to IDLE. An output transfer together with an input transfer loads that word into a fresh accumulator: non-last goes to ACCUM, last reloads the result and stays in DONE.
- Last-word transfer:
  - out_parity <= acc ^ (^in_data) ^ odd_mode.
  - out_error <= out_parity_next != in_parity.
  - out_words <= words+1, saturating.
  - out_valid <= 1.
  - Accumulator and word counter clear.
  - Latency: one cycle from last-word transfer to out_valid.
- Result registers are stable while out_valid=1 and out_ready=0.
- error_count:
  - Increments on the cycle a result with an error is loaded; saturates at all-ones.
  - clear_count zeroes it.
  - clear_count together with an error load gives 1.
- Single-word packets (IDLE plus last) are legal.

Optional Feature:
PARITY_LANE_EN
- Defined: adds port out_lane_parity, out, LANES bits. Bit i is the parity of data bits [(i+1)*WIDTH/LANES-1 : i*WIDTH/LANES], accumulated over the packet with odd_mode applied per lane. It is registered and held alongside out_parity and has the same reset value 0.
- Undefined: the port and the lane accumulators are absent. All other behaviour is identical.

Test Plan:
- Even mode, WIDTH=32. Words 0x00000001, then 0x00000003 with last and in_parity=1. Required: one cycle later out_valid=1, out_parity=1, out_error=0, out_words=2, error_count=0.
- odd_mode=1. Single word 0x0000000F with last and in_parity=0. Required: out_parity=1, out_error=1, out_words=1, error_count=1.
- Backpressure. Hold out_ready=0 with a result pending. Required: in_ready=0, further in_valid is ignored, and the result is unchanged for 5 cycles. Then assert out_ready=1 and send single-word last 0x80000000 (even mode, in_parity=1) in the same cycle. Required: out_valid stays 1, and next cycle out_parity=1, out_error=0, out_words=1.
- CNT_WIDTH=4. Send 17 single-word error packets. Required: error_count saturates at 15. Then assert clear_count together with an error load. Required: error_count=1.
- Reset mid-packet. Send 2 non-last words, then reset=0 for 1 cycle. Required: out_valid=0, counters 0. Then send 0x00000001 with last and in_parity=1. Required: out_words=1, out_parity=1, out_error=0.
- PARITY_LANE_EN defined, even mode, LANES=4. Single word 0x01020300 with last. Required: out_lane_parity=4'b1100 (lane0 = bits 7:0) and out_parity=0.
